// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and limits for the instruction/data memory arbiter.
//   arb_state_e   - arbiter FSM states (IDLE, WAIT, RESP)
//   requester_e   - identifies the fetch or load/store requester
//   MaxMemLatency - largest supported memory read latency in cycles
//   CntBits       - width of the latency down-counter
package riscv_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;

    typedef enum logic {REQ_IFETCH, REQ_LSU} requester_e;

    localparam int MaxMemLatency = 15;
    localparam int CntBits       = $clog2(MaxMemLatency + 1);

endpackage

// File: rtl/riscv_rr_arbiter2.sv
// riscv_rr_arbiter2: combinational two-way round-robin pick.
//   req0_i       - request from requester 0 (instruction fetch)
//   req1_i       - request from requester 1 (load/store)
//   last_grant_i - requester that won the previous grant
//   gnt_o        - one-hot pick, bit 0 = req0, bit 1 = req1, zero if no request
module riscv_rr_arbiter2
    import riscv_mem_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  requester_e last_grant_i,
    output logic [1:0] gnt_o
);

    // A lone request always wins; under contention the one that did not win last time goes.
    always_comb begin
        gnt_o[0] = req0_i && (!req1_i || last_grant_i == REQ_LSU);
        gnt_o[1] = req1_i && (!req0_i || last_grant_i == REQ_IFETCH);
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port synchronous memory between fetch and load/store.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   ifetch_req/addr_i   - fetch request held until ifetch_gnt_o
//   ifetch_gnt_o        - fetch accepted this cycle (combinational)
//   ifetch_rvalid/rdata - registered one-cycle instruction return
//   lsu_req/we/be/addr/wdata_i - load/store request held until lsu_gnt_o
//   lsu_gnt_o           - load/store accepted this cycle (combinational)
//   lsu_rvalid/rdata    - registered one-cycle load data or store ack (data 0)
//   mem_req/we/be/addr/wdata_o - memory access, driven only in the grant cycle
//   mem_rdata_i         - memory read data, valid MemLatency cycles after mem_req_o
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MemAddrBits = 32,
    parameter int DataBits    = 32,
    parameter int MemLatency  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ifetch_req_i,
    input  logic [MemAddrBits-1:0]  ifetch_addr_i,
    output logic                    ifetch_gnt_o,
    output logic                    ifetch_rvalid_o,
    output logic [DataBits-1:0]     ifetch_rdata_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DataBits/8-1:0]   lsu_be_i,
    input  logic [MemAddrBits-1:0]  lsu_addr_i,
    input  logic [DataBits-1:0]     lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DataBits-1:0]     lsu_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DataBits/8-1:0]   mem_be_o,
    output logic [MemAddrBits-1:0]  mem_addr_o,
    output logic [DataBits-1:0]     mem_wdata_o,
    input  logic [DataBits-1:0]     mem_rdata_i
);

    localparam int                BeBits  = DataBits / 8;
    localparam logic [CntBits-1:0] LoadCnt = CntBits'(MemLatency - 1);

    arb_state_e          state_q, state_d;
    logic [CntBits-1:0]  cnt_q, cnt_d;
    // The last winner is also the owner of the single outstanding access.
    requester_e          last_q, last_d;
    logic                we_q, we_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                lsu_rvalid_q, lsu_rvalid_d;
    logic [DataBits-1:0] if_rdata_q, if_rdata_d;
    logic [DataBits-1:0] lsu_rdata_q, lsu_rdata_d;
    logic [1:0]          pick;
    logic                can_grant, gnt_if, gnt_lsu, grant, last_beat;

    riscv_rr_arbiter2 u_rr (
        .req0_i       (ifetch_req_i),
        .req1_i       (lsu_req_i),
        .last_grant_i (last_q),
        .gnt_o        (pick)
    );

    always_comb begin
        // Reset gating keeps every output low while rst_i is held.
        can_grant    = !rst_i && (state_q == IDLE || state_q == RESP);
        gnt_if       = can_grant && pick[0];
        gnt_lsu      = can_grant && pick[1];
        grant        = gnt_if || gnt_lsu;
        last_beat    = state_q == WAIT && cnt_q == '0;
        state_d      = grant ? WAIT : last_beat ? RESP : (state_q == WAIT) ? WAIT : IDLE;
        cnt_d        = grant ? LoadCnt : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        last_d       = gnt_if ? REQ_IFETCH : gnt_lsu ? REQ_LSU : last_q;
        we_d         = grant ? (gnt_lsu && lsu_we_i) : we_q;
        if_rvalid_d  = last_beat && last_q == REQ_IFETCH;
        lsu_rvalid_d = last_beat && last_q == REQ_LSU;
        if_rdata_d   = if_rvalid_d ? mem_rdata_i : if_rdata_q;
        // Stores acknowledge with zero data rather than whatever the memory drives.
        lsu_rdata_d  = lsu_rvalid_d ? (we_q ? '0 : mem_rdata_i) : lsu_rdata_q;
    end

    always_comb begin
        ifetch_gnt_o    = gnt_if;
        lsu_gnt_o       = gnt_lsu;
        mem_req_o       = grant;
        mem_we_o        = gnt_lsu && lsu_we_i;
        mem_be_o        = gnt_lsu ? lsu_be_i : {BeBits{gnt_if}};
        mem_addr_o      = gnt_lsu ? lsu_addr_i : gnt_if ? ifetch_addr_i : '0;
        mem_wdata_o     = gnt_lsu ? lsu_wdata_i : '0;
        ifetch_rvalid_o = if_rvalid_q;
        ifetch_rdata_o  = if_rdata_q;
        lsu_rvalid_o    = lsu_rvalid_q;
        lsu_rdata_o     = lsu_rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= REQ_LSU;
            we_q         <= 1'b0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            we_q         <= we_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench for the fetch/load-store memory arbiter.
module tb_riscv_mem_arbiter;

    localparam int L = 2;

    typedef struct packed {
        logic        who;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        has_rsp;
        logic [31:0] rdata;
    } txn_t;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        ifetch_req_i, ifetch_gnt_o, ifetch_rvalid_o;
    logic [31:0] ifetch_addr_i, ifetch_rdata_o;
    logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic        b_ifetch_gnt_o, b_ifetch_rvalid_o;
    logic [31:0] b_ifetch_rdata_o;
    logic        b_lsu_req_i, b_lsu_gnt_o, b_lsu_rvalid_o;
    logic [3:0]  b_lsu_be_i;
    logic [31:0] b_lsu_addr_i, b_lsu_rdata_o;
    logic        b_mem_req_o, b_mem_we_o;
    logic [3:0]  b_mem_be_o;
    logic [31:0] b_mem_addr_o, b_mem_wdata_o, b_mem_rdata_i;

    riscv_mem_arbiter #(.MemAddrBits(32), .DataBits(32), .MemLatency(L)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ifetch_req_i(ifetch_req_i), .ifetch_addr_i(ifetch_addr_i), .ifetch_gnt_o(ifetch_gnt_o),
        .ifetch_rvalid_o(ifetch_rvalid_o), .ifetch_rdata_o(ifetch_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    riscv_mem_arbiter #(.MemAddrBits(32), .DataBits(32), .MemLatency(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst_i),
        .ifetch_req_i(1'b0), .ifetch_addr_i(32'h0), .ifetch_gnt_o(b_ifetch_gnt_o),
        .ifetch_rvalid_o(b_ifetch_rvalid_o), .ifetch_rdata_o(b_ifetch_rdata_o),
        .lsu_req_i(b_lsu_req_i), .lsu_we_i(1'b0), .lsu_be_i(b_lsu_be_i), .lsu_addr_i(b_lsu_addr_i),
        .lsu_wdata_i(32'h0), .lsu_gnt_o(b_lsu_gnt_o), .lsu_rvalid_o(b_lsu_rvalid_o),
        .lsu_rdata_o(b_lsu_rdata_o),
        .mem_req_o(b_mem_req_o), .mem_we_o(b_mem_we_o), .mem_be_o(b_mem_be_o), .mem_addr_o(b_mem_addr_o),
        .mem_wdata_o(b_mem_wdata_o), .mem_rdata_i(b_mem_rdata_i)
    );

    // Memory content: a fixed instruction at 0x100, otherwise {addr[15:0]^0x1234, addr[15:0]}.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    // Latency pipes; idle slots carry a poison value so mistimed sampling is visible.
    logic [31:0] pipe_a0, pipe_a1, pipe_b0;
    always @(posedge clk) begin
        pipe_a0 <= mem_req_o ? memf(mem_addr_o) : 32'hBAD0_BAD0;
        pipe_a1 <= pipe_a0;
        pipe_b0 <= b_mem_req_o ? memf(b_mem_addr_o) : 32'hBAD0_BAD0;
    end
    assign mem_rdata_i   = pipe_a1;
    assign b_mem_rdata_i = pipe_b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    txn_t if_q[$], ls_q[$], exp_q[$];
    rsp_t pend_q[$];
    int   gcyc_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic txn_t mk(input logic who, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic has_rsp, input logic [31:0] rdata);
        return '{who, addr, we, be, wdata, has_rsp, rdata};
    endfunction

    // Requester models: present the head of each queue, retire it after its grant.
    initial begin
        logic if_took, ls_took;
        #2;
        forever begin
            ifetch_req_i = if_q.size() != 0;
            if (if_q.size() != 0) ifetch_addr_i = if_q[0].addr;
            lsu_req_i = ls_q.size() != 0;
            if (ls_q.size() != 0) begin
                lsu_addr_i  = ls_q[0].addr;
                lsu_we_i    = ls_q[0].we;
                lsu_be_i    = ls_q[0].be;
                lsu_wdata_i = ls_q[0].wdata;
            end
            @(negedge clk);
            if_took = ifetch_gnt_o;
            ls_took = lsu_gnt_o;
            @(posedge clk);
            #1;
            if (if_took && if_q.size() != 0) void'(if_q.pop_front());
            if (ls_took && ls_q.size() != 0) void'(ls_q.pop_front());
        end
    end

    // Monitor: grants pop the expected-grant queue, rvalid pulses pop the response queue.
    initial begin
        txn_t        e;
        rsp_t        r;
        logic [31:0] last_if, last_ls;
        last_if = '0;
        last_ls = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                last_if = '0;
                last_ls = '0;
            end else begin
                chk("mem_req_we_vs_gnt", {mem_req_o, mem_we_o && !(ifetch_gnt_o || lsu_gnt_o)},
                    {ifetch_gnt_o || lsu_gnt_o, 1'b0});
                if (ifetch_gnt_o || lsu_gnt_o) begin
                    chk("gnt_both_high", ifetch_gnt_o & lsu_gnt_o, 0);
                    gcyc_q.push_back(cyc);
                    if (exp_q.size() == 0) chk("gnt_unexpected", {ifetch_gnt_o, lsu_gnt_o}, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("gnt_who", {ifetch_gnt_o, lsu_gnt_o}, e.who ? 2'b01 : 2'b10);
                        chk("gnt_mem_fields", {mem_we_o, mem_be_o, mem_addr_o, e.we ? mem_wdata_o : 32'h0},
                            {e.we, e.be, e.addr, e.we ? e.wdata : 32'h0});
                        if (e.has_rsp) pend_q.push_back('{e.who, e.rdata, cyc + L + 1});
                    end
                end
                if (ifetch_rvalid_o || lsu_rvalid_o) begin
                    if (pend_q.size() == 0) chk("rvalid_unexpected", {ifetch_rvalid_o, lsu_rvalid_o}, 0);
                    else begin
                        r = pend_q.pop_front();
                        chk("rvalid_who", {ifetch_rvalid_o, lsu_rvalid_o}, r.who ? 2'b01 : 2'b10);
                        chk("rvalid_cycle", cyc, r.cyc);
                        chk("rdata", r.who ? lsu_rdata_o : ifetch_rdata_o, r.rdata);
                        chk("other_rdata_held", r.who ? ifetch_rdata_o : lsu_rdata_o, r.who ? last_if : last_ls);
                        if (r.who) last_ls = r.rdata;
                        else last_if = r.rdata;
                    end
                end else if (pend_q.size() != 0 && cyc > pend_q[0].cyc) begin
                    chk("rvalid_missing", cyc, pend_q[0].cyc);
                    void'(pend_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0 || if_q.size() != 0 || ls_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < 200, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] baddr[3] = '{32'h10, 32'h14, 32'h18};
    logic [31:0] bdat[3]  = '{32'h1224_0010, 32'h1220_0014, 32'h122C_0018};
    logic        exp_g[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_v[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_i = 1'b1;
        ifetch_req_i = 1'b0; ifetch_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        b_lsu_req_i = 1'b0; b_lsu_be_i = 4'hF; b_lsu_addr_i = '0;

        // Reset with both requesters pending; first contention must go to fetch.
        if_q.push_back(mk(0, 32'h40, 0, 4'hF, 0, 0, 0));
        ls_q.push_back(mk(1, 32'h80, 0, 4'hF, 0, 0, 0));
        exp_q.push_back(mk(0, 32'h40, 0, 4'hF, 0, 1, 32'h1274_0040));
        exp_q.push_back(mk(1, 32'h80, 0, 4'hF, 0, 1, 32'h12B4_0080));
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs_zero", |{ifetch_gnt_o, ifetch_rvalid_o, ifetch_rdata_o, lsu_gnt_o, lsu_rvalid_o,
                lsu_rdata_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
        end
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("first_gnt_ifetch", {ifetch_gnt_o, lsu_gnt_o, mem_addr_o}, {2'b10, 32'h40});
        drain();

        // Both held for six grants: strict alternation, one grant every L+1 cycles.
        gcyc_q.delete();
        if_q.push_back(mk(0, 32'h104, 0, 4'hF, 0, 0, 0));
        if_q.push_back(mk(0, 32'h108, 0, 4'hF, 0, 0, 0));
        if_q.push_back(mk(0, 32'h10C, 0, 4'hF, 0, 0, 0));
        ls_q.push_back(mk(1, 32'h180, 0, 4'hF, 0, 0, 0));
        ls_q.push_back(mk(1, 32'h184, 0, 4'hF, 0, 0, 0));
        ls_q.push_back(mk(1, 32'h188, 0, 4'hF, 0, 0, 0));
        exp_q.push_back(mk(0, 32'h104, 0, 4'hF, 0, 1, 32'h1330_0104));
        exp_q.push_back(mk(1, 32'h180, 0, 4'hF, 0, 1, 32'h13B4_0180));
        exp_q.push_back(mk(0, 32'h108, 0, 4'hF, 0, 1, 32'h133C_0108));
        exp_q.push_back(mk(1, 32'h184, 0, 4'hF, 0, 1, 32'h13B0_0184));
        exp_q.push_back(mk(0, 32'h10C, 0, 4'hF, 0, 1, 32'h1338_010C));
        exp_q.push_back(mk(1, 32'h188, 0, 4'hF, 0, 1, 32'h13BC_0188));
        drain();
        chk("contention_grant_count", gcyc_q.size(), 6);
        for (int i = 1; i < gcyc_q.size(); i++) chk("grant_spacing", gcyc_q[i] - gcyc_q[i-1], L + 1);

        // Lone fetch of a real instruction word.
        if_q.push_back(mk(0, 32'h100, 0, 4'hF, 0, 0, 0));
        exp_q.push_back(mk(0, 32'h100, 0, 4'hF, 0, 1, 32'h0050_0093));
        drain();

        // Partial store: write strobes only in the grant cycle, zero data on the ack.
        ls_q.push_back(mk(1, 32'h200, 1, 4'b0011, 32'hDEAD_BEEF, 0, 0));
        exp_q.push_back(mk(1, 32'h200, 1, 4'b0011, 32'hDEAD_BEEF, 1, 32'h0));
        drain();

        // Reset during WAIT: access abandoned, arbiter idle and fetch-first right after release.
        begin
            int n = 0;
            if_q.push_back(mk(0, 32'h300, 0, 4'hF, 0, 0, 0));
            exp_q.push_back(mk(0, 32'h300, 0, 4'hF, 0, 0, 0));
            while (!ifetch_gnt_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("abandoned_fetch_granted", ifetch_gnt_o, 1);
        end
        if_q.push_back(mk(0, 32'h304, 0, 4'hF, 0, 0, 0));
        ls_q.push_back(mk(1, 32'h204, 0, 4'hF, 0, 0, 0));
        exp_q.push_back(mk(0, 32'h304, 0, 4'hF, 0, 1, 32'h1130_0304));
        exp_q.push_back(mk(1, 32'h204, 0, 4'hF, 0, 1, 32'h1030_0204));
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_gnt_ifetch", {ifetch_gnt_o, lsu_gnt_o}, 2'b10);
        drain();

        // Latency-1 instance: back-to-back loads, each new grant coincides with an rvalid.
        begin
            int ng = 0;
            int nv = 0;
            @(posedge clk);
            #1;
            b_lsu_req_i  = 1'b1;
            b_lsu_addr_i = baddr[0];
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                chk("l1_gnt", b_lsu_gnt_o, exp_g[c]);
                chk("l1_rvalid", b_lsu_rvalid_o, exp_v[c]);
                chk("l1_be", b_mem_be_o, {4{exp_g[c]}});
                chk("l1_quiet", {b_ifetch_gnt_o, b_ifetch_rvalid_o, b_mem_we_o, b_ifetch_rdata_o, b_mem_wdata_o}, 0);
                if (b_lsu_rvalid_o && nv < 3) begin
                    chk("l1_rdata", b_lsu_rdata_o, bdat[nv]);
                    nv++;
                end
                if (b_lsu_gnt_o) ng++;
                @(posedge clk);
                #1;
                b_lsu_req_i = ng < 3;
                if (ng < 3) b_lsu_addr_i = baddr[ng];
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
